gpio_serial_loader: RTL and testbench



---
 rtl/gpio_serial_loader.sv | 187 ++++++++++++++++++
 tb/tb_gpio_serial_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_loader.sv
// Serial configuration loader for the GPIO pad ring: fetches per-pad words and shifts them into two chains.
// Optional bit-bang override of the serial pins is compiled in with `define GPIO_LOADER_BITBANG_EN.
module gpio_serial_loader #(
  parameter int NPADS     = 38,
  parameter int AREA1PADS = 19,
  parameter int CFG_W     = 13,
  parameter int CLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             cfg_rd,
  output logic [5:0]       cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             serial_clock,
  output logic             serial_load,
  output logic             serial_data_1,
  output logic             serial_data_2
`ifdef GPIO_LOADER_BITBANG_EN
  ,
  input  logic             bb_en,
  input  logic             bb_clock,
  input  logic             bb_load,
  input  logic             bb_data_1,
  input  logic             bb_data_2
`endif
);

  localparam int L1 = AREA1PADS;
  localparam int L2 = NPADS - AREA1PADS;
  localparam int R  = (L1 > L2) ? L1 : L2;
  localparam int D1 = R - L1;
  localparam int D2 = R - L2;
  localparam int PH = 2 * CLK_DIV;
  localparam int PW = $clog2(PH);
  localparam int BW = $clog2(CFG_W + 1);
  localparam int RW = $clog2(R + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(PH - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_W - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(R - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [RW-1:0]    rnd;
  logic [1:0]       fc;
  logic [PW-1:0]    ph;
  logic [BW-1:0]    bitc;
  logic [CFG_W-1:0] sh1, sh2;
  logic             dat1, dat2;

  logic             dummy1, dummy2;
  logic [5:0]       addr1, addr2;
  logic [CFG_W-1:0] w2;
  logic             fsm_sclk, fsm_load;

  // The shorter chain pads its leading rounds with zero words so both chains finish together.
  assign dummy1 = (int'(rnd) < D1);
  assign dummy2 = (int'(rnd) < D2);
  assign addr1  = 6'(R - 1 - int'(rnd));
  assign addr2  = 6'(NPADS - R + int'(rnd));
  assign w2     = dummy2 ? '0 : cfg_data;

  assign busy     = (state == S_FETCH) || (state == S_SHIFT) || (state == S_LOAD);
  assign done     = (state == S_DONE);
  assign cfg_rd   = (state == S_FETCH) && (((fc == 2'd0) && !dummy1) || ((fc == 2'd1) && !dummy2));
  assign cfg_addr = cfg_rd ? ((fc == 2'd0) ? addr1 : addr2) : 6'd0;
  assign fsm_sclk = (state == S_SHIFT) && (int'(ph) >= CLK_DIV);
  assign fsm_load = (state == S_LOAD) && (int'(ph) < CLK_DIV);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      rnd   <= '0;
      fc    <= '0;
      ph    <= '0;
      bitc  <= '0;
      sh1   <= '0;
      sh2   <= '0;
      dat1  <= 1'b0;
      dat2  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dat1 <= 1'b0;
          dat2 <= 1'b0;
          if (start) begin
            state <= S_FETCH;
            rnd   <= '0;
            fc    <= '0;
          end
        end
        S_FETCH: begin
          case (fc)
            2'd0: fc <= 2'd1;
            2'd1: begin
              sh1 <= dummy1 ? '0 : cfg_data;
              fc  <= 2'd2;
            end
            default: begin
              // First bit goes out together with the entry into SHIFT.
              dat1  <= sh1[CFG_W-1];
              sh1   <= sh1 << 1;
              dat2  <= w2[CFG_W-1];
              sh2   <= w2 << 1;
              ph    <= '0;
              bitc  <= '0;
              fc    <= '0;
              state <= S_SHIFT;
            end
          endcase
        end
        S_SHIFT: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            if (bitc == BIT_LAST) begin
              if (rnd == R_LAST) begin
                state <= S_LOAD;
              end else begin
                rnd   <= rnd + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              bitc <= bitc + 1'b1;
              dat1 <= sh1[CFG_W-1];
              sh1  <= sh1 << 1;
              dat2 <= sh2[CFG_W-1];
              sh2  <= sh2 << 1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        S_LOAD: begin
          // Strobe for the first half, then a quiet half before reporting completion.
          if (ph == PH_LAST) state <= S_DONE;
          else ph <= ph + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          dat1  <= 1'b0;
          dat2  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GPIO_LOADER_BITBANG_EN
  logic bb_act, bb_c, bb_l, bb_d1, bb_d2, bb_sel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bb_act <= 1'b0;
      bb_c   <= 1'b0;
      bb_l   <= 1'b0;
      bb_d1  <= 1'b0;
      bb_d2  <= 1'b0;
    end else begin
      bb_act <= bb_en;
      bb_c   <= bb_clock;
      bb_l   <= bb_load;
      bb_d1  <= bb_data_1;
      bb_d2  <= bb_data_2;
    end
  end

  // Override only takes effect while idle; the FSM owns the pins once a load starts.
  assign bb_sel        = (state == S_IDLE) && bb_act;
  assign serial_clock  = bb_sel ? bb_c  : fsm_sclk;
  assign serial_load   = bb_sel ? bb_l  : fsm_load;
  assign serial_data_1 = bb_sel ? bb_d1 : dat1;
  assign serial_data_2 = bb_sel ? bb_d2 : dat2;
`else
  assign serial_clock  = fsm_sclk;
  assign serial_load   = fsm_load;
  assign serial_data_1 = dat1;
  assign serial_data_2 = dat2;
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: three parameterisations driven against a shift-chain pad model.
module tb_gpio_serial_loader;
  localparam int NI  = 3;
  localparam int NP  = 38;
  localparam int CW  = 13;
  localparam int CHB = 20 * CW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] busy_v, done_v, rd_v, sclk_v, sload_v, sd1_v, sd2_v;
  logic [5:0]    addr_v [NI];
  logic [CW-1:0] cdat   [NI];

`ifdef GPIO_LOADER_BITBANG_EN
  logic bb_en = 1'b0, bb_clock = 1'b0, bb_load = 1'b0, bb_data_1 = 1'b0, bb_data_2 = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: CLK_DIV=1. Instance 2: unequal chains (18/20).
  gpio_serial_loader #(.NPADS(38), .AREA1PADS(19), .CFG_W(13), .CLK_DIV(2)) u0 (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .cfg_rd(rd_v[0]), .cfg_addr(addr_v[0]), .cfg_data(cdat[0]), .serial_clock(sclk_v[0]),
    .serial_load(sload_v[0]), .serial_data_1(sd1_v[0]), .serial_data_2(sd2_v[0])
`ifdef GPIO_LOADER_BITBANG_EN
    , .bb_en(bb_en), .bb_clock(bb_clock), .bb_load(bb_load), .bb_data_1(bb_data_1), .bb_data_2(bb_data_2)
`endif
  );

  gpio_serial_loader #(.NPADS(38), .AREA1PADS(19), .CFG_W(13), .CLK_DIV(1)) u1 (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .cfg_rd(rd_v[1]), .cfg_addr(addr_v[1]), .cfg_data(cdat[1]), .serial_clock(sclk_v[1]),
    .serial_load(sload_v[1]), .serial_data_1(sd1_v[1]), .serial_data_2(sd2_v[1])
`ifdef GPIO_LOADER_BITBANG_EN
    , .bb_en(1'b0), .bb_clock(1'b0), .bb_load(1'b0), .bb_data_1(1'b0), .bb_data_2(1'b0)
`endif
  );

  gpio_serial_loader #(.NPADS(38), .AREA1PADS(18), .CFG_W(13), .CLK_DIV(2)) u2 (
    .clk(clk), .resetn(resetn), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .cfg_rd(rd_v[2]), .cfg_addr(addr_v[2]), .cfg_data(cdat[2]), .serial_clock(sclk_v[2]),
    .serial_load(sload_v[2]), .serial_data_1(sd1_v[2]), .serial_data_2(sd2_v[2])
`ifdef GPIO_LOADER_BITBANG_EN
    , .bb_en(1'b0), .bb_clock(1'b0), .bb_load(1'b0), .bb_data_1(1'b0), .bb_data_2(1'b0)
`endif
  );

  function automatic int t_of(input int k);
    case (k)
      0:       return 1049;
      1:       return 553;
      default: return 1104;
    endcase
  endfunction
  function automatic int r_of(input int k);  return (k == 2) ? 20 : 19; endfunction
  function automatic int cd_of(input int k); return (k == 1) ? 1 : 2;   endfunction
  function automatic int a1_of(input int k); return (k == 2) ? 18 : 19; endfunction

  // Configuration table: word[i] = i ^ 0x1A5; unread cycles return all-ones.
  always @(posedge clk)
    for (int k = 0; k < NI; k++)
      cdat[k] <= rd_v[k] ? (CW'(addr_v[k]) ^ 13'h1A5) : 13'h1FFF;

  int busy_cnt [NI] = '{default:0};
  int done_cnt [NI] = '{default:0};
  int rd_cnt   [NI] = '{default:0};
  int rise_cnt [NI] = '{default:0};
  int hi_cnt   [NI] = '{default:0};
  int ld_cnt   [NI] = '{default:0};
  int viol_cnt [NI] = '{default:0};
  int nr       [NI] = '{default:0};
  logic [CHB-1:0] ch1 [NI] = '{default:'0};
  logic [CHB-1:0] ch2 [NI] = '{default:'0};
  logic [CW-1:0]  fw1 [NI] = '{default:'0};
  logic [CW-1:0]  lat [NI][NP] = '{default:'0};
  logic [NI-1:0]  p_sclk = '0, p_sload = '0, p_sd1 = '0, p_sd2 = '0, p_busy = '0;

  // Pad-chain model: each chain samples on the serial_clock rising edge, pads latch on serial_load.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (busy_v[k])  busy_cnt[k] <= busy_cnt[k] + 1;
      if (done_v[k])  done_cnt[k] <= done_cnt[k] + 1;
      if (rd_v[k])    rd_cnt[k]   <= rd_cnt[k] + 1;
      if (sclk_v[k])  hi_cnt[k]   <= hi_cnt[k] + 1;
      if (sload_v[k]) ld_cnt[k]   <= ld_cnt[k] + 1;
      if (sclk_v[k] && (sload_v[k] || sd1_v[k] !== p_sd1[k] || sd2_v[k] !== p_sd2[k]))
        viol_cnt[k] <= viol_cnt[k] + 1;
      if (busy_v[k] && !p_busy[k]) begin
        nr[k] <= 0;
      end else if (sclk_v[k] && !p_sclk[k]) begin
        ch1[k]      <= {ch1[k][CHB-2:0], sd1_v[k]};
        ch2[k]      <= {ch2[k][CHB-2:0], sd2_v[k]};
        rise_cnt[k] <= rise_cnt[k] + 1;
        if (nr[k] < CW) fw1[k] <= {fw1[k][CW-2:0], sd1_v[k]};
        nr[k] <= nr[k] + 1;
      end
      if (sload_v[k] && !p_sload[k])
        for (int p = 0; p < NP; p++)
          lat[k][p] <= (p < a1_of(k)) ? ch1[k][p*CW +: CW] : ch2[k][(NP-1-p)*CW +: CW];
    end
    p_sclk  <= sclk_v;
    p_sload <= sload_v;
    p_sd1   <= sd1_v;
    p_sd2   <= sd2_v;
    p_busy  <= busy_v;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input int k);
    chk(tag, {busy_v[k], done_v[k], rd_v[k], addr_v[k], sclk_v[k], sload_v[k], sd1_v[k], sd2_v[k]}, 64'd0);
  endtask

  task automatic run_load(input int k, input bit repulse, input bit start_on_done);
    int b0, d0, r0, v0, h0, s0, l0;
    bit seen;
    b0 = busy_cnt[k]; d0 = done_cnt[k]; r0 = rd_cnt[k]; v0 = viol_cnt[k];
    h0 = hi_cnt[k];   s0 = rise_cnt[k]; l0 = ld_cnt[k];
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (repulse && (c == 10 || c == 500)) start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      if (done_v[k]) seen = 1'b1;
    end
    if (start_on_done && seen) begin
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
    end
    repeat (6) @(negedge clk);
    #1;
    chk($sformatf("done_seen[%0d]", k),    seen, 1);
    chk($sformatf("busy_cycles[%0d]", k),  busy_cnt[k] - b0, t_of(k));
    chk($sformatf("done_pulses[%0d]", k),  done_cnt[k] - d0, 1);
    chk($sformatf("cfg_rd_count[%0d]", k), rd_cnt[k] - r0, 38);
    chk($sformatf("sclk_rises[%0d]", k),   rise_cnt[k] - s0, r_of(k) * CW);
    chk($sformatf("sclk_high[%0d]", k),    hi_cnt[k] - h0, r_of(k) * CW * cd_of(k));
    chk($sformatf("load_high[%0d]", k),    ld_cnt[k] - l0, cd_of(k));
    chk($sformatf("timing_viol[%0d]", k),  viol_cnt[k] - v0, 0);
    chk_idle_outputs($sformatf("idle_after[%0d]", k), k);
    for (int p = 0; p < NP; p++)
      chk($sformatf("pad[%0d][%0d]", k, p), lat[k][p], 64'(p ^ 'h1A5));
  endtask

  initial begin
    int l0, d0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) chk_idle_outputs($sformatf("reset_state[%0d]", k), k);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    run_load(0, 1'b0, 1'b0);
    chk("chain1_first_word[0]", fw1[0], 13'h1B7);
    run_load(1, 1'b0, 1'b0);
    run_load(2, 1'b0, 1'b0);
    chk("chain1_lead_dummy[2]", fw1[2], 13'h0);

    // Extra starts while busy and on the DONE cycle must be ignored.
    run_load(0, 1'b1, 1'b1);

    // Reset in the middle of round 7's shift phase.
    l0 = ld_cnt[0]; d0 = done_cnt[0];
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (399) @(negedge clk);
    chk("busy_before_reset", busy_v[0], 1);
    resetn = 1'b0;
    #1;
    chk_idle_outputs("async_reset_outputs", 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("no_load_after_reset", ld_cnt[0] - l0, 0);
    chk("no_done_after_reset", done_cnt[0] - d0, 0);
    @(negedge clk);
    run_load(0, 1'b0, 1'b0);

`ifdef GPIO_LOADER_BITBANG_EN
    @(negedge clk);
    bb_en = 1'b1; bb_data_1 = 1'b1; bb_clock = 1'b1;
    #1;
    chk("bb_latency", {sclk_v[0], sd1_v[0]}, 2'b00);
    @(negedge clk);
    chk("bb_follow", {sclk_v[0], sd1_v[0]}, 2'b11);
    bb_clock = 1'b0;
    @(negedge clk);
    chk("bb_toggle", {sclk_v[0], sd1_v[0]}, 2'b01);
    bb_data_1 = 1'b0;
    @(negedge clk);
    run_load(0, 1'b0, 1'b0);
    bb_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
